// File: rtl/secuenciador_rst_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, default
// sizing constants and a small helper used to size the hold/gap counter.
package secuenciador_rst_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,  // all domains out of reset
    HOLD_ST = 2'd1,  // all domains in reset, counting the hold time
    RELEASE = 2'd2   // releasing domains one by one in index order
  } state_t;

  localparam int N_DEF    = 3;
  localparam int HOLD_DEF = 8;
  localparam int GAP_DEF  = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/secuenciador_rst_if.sv
// Request/status bundle of the reset sequencer.
//   ext_req : external reset request, asynchronous level
//   sw_req  : software reset request, synchronous to clk
//   rst_out : per-domain reset, active-high
//   busy    : any domain still in reset
//   done    : one-cycle pulse when the last domain is released
// master = requester / observer side, slave = the sequencer.
interface secuenciador_rst_if
  import secuenciador_rst_pkg::*;
#(
  parameter int N = N_DEF
) ();

  logic         ext_req;
  logic         sw_req;
  logic [N-1:0] rst_out;
  logic         busy;
  logic         done;

  modport master (output ext_req, sw_req, input  rst_out, busy, done);
  modport slave  (input  ext_req, sw_req, output rst_out, busy, done);

endinterface

// File: rtl/secuenciador_rst_sincronizador_2ff.sv
// sincronizador_2ff: two-flop synchroniser for the asynchronous external
// reset request, with an optional glitch filter.
//   clk, rst : clock and synchronous active-high reset (clears every flop)
//   d        : asynchronous input
//   q        : synchronised (and optionally filtered) request
// Build option SECUENCIADOR_RST_FILTRO_EN: q only rises after three
// consecutive high synchronised samples, so shorter pulses are dropped
// and the request latency grows by two cycles.
module sincronizador_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] sync_pipe;

  always_ff @(posedge clk) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[0], d};
  end

`ifdef SECUENCIADOR_RST_FILTRO_EN
  // Two more samples of the synchronised level; all three must agree.
  logic [1:0] filt_pipe;

  always_ff @(posedge clk) begin
    if (rst) filt_pipe <= '0;
    else     filt_pipe <= {filt_pipe[0], sync_pipe[1]};
  end

  assign q = sync_pipe[1] & (&filt_pipe);
`else
  assign q = sync_pipe[1];
`endif

endmodule

// File: rtl/secuenciador_rst.sv
// secuenciador_rst: reset sequencer. Any request (software, synchronised
// external, or rst itself) puts every domain in reset; after HOLD quiet
// cycles domain 0 is released, then one more domain every GAP cycles.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, behaves like a request
//   bus  : secuenciador_rst_if.slave (ext_req, sw_req, rst_out, busy, done)
// Parameters: N domains, HOLD hold cycles, GAP cycles between releases.
// Build option SECUENCIADOR_RST_FILTRO_EN enables the ext_req glitch filter
// inside sincronizador_2ff.
module secuenciador_rst
  import secuenciador_rst_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int HOLD = HOLD_DEF,
  parameter int GAP  = GAP_DEF
) (
  input  logic               clk,
  input  logic               rst,
  secuenciador_rst_if.slave  bus
);

  localparam int CW = $clog2(max2(HOLD, GAP) + 1);

  logic         ext_sync;
  logic         req;
  state_t       state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0] rst_q, rst_nxt;
  logic         busy_q, done_q, done_nxt;

  sincronizador_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.ext_req),
    .q   (ext_sync)
  );

  assign req = bus.sw_req | ext_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= HOLD_ST;
      cnt    <= '0;
      rst_q  <= '1;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rst_q  <= rst_nxt;
      busy_q <= |rst_nxt;
      done_q <= done_nxt;
    end
  end

  // Domains are released in index order, so the still-asserted bits are
  // always a contiguous top block; shifting left releases the lowest one.
  // Counters restart at every release, hence they never exceed HOLD-1/GAP-1.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rst_nxt   = rst_q;
    done_nxt  = 1'b0;
    if (req) begin
      state_nxt = HOLD_ST;
      cnt_nxt   = '0;
      rst_nxt   = '1;
    end else begin
      case (state)
        IDLE: ;
        HOLD_ST: begin
          if (cnt == CW'(HOLD - 1)) begin
            rst_nxt   = rst_q << 1;
            cnt_nxt   = '0;
            state_nxt = (rst_nxt == '0) ? IDLE : RELEASE;
            done_nxt  = (rst_nxt == '0);
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt == CW'(GAP - 1)) begin
            rst_nxt   = rst_q << 1;
            cnt_nxt   = '0;
            state_nxt = (rst_nxt == '0) ? IDLE : RELEASE;
            done_nxt  = (rst_nxt == '0);
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = HOLD_ST;
          cnt_nxt   = '0;
          rst_nxt   = '1;
        end
      endcase
    end
  end

  assign bus.rst_out = rst_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_secuenciador_rst.sv
// Bench for secuenciador_rst (N=3, HOLD=8, GAP=4). Expected per-edge
// outputs are derived from the last request edge r: bit i is high while
// e < r+HOLD+GAP*i, done is high only at e == r+HOLD+GAP*(N-1).
module tb_secuenciador_rst;
  import secuenciador_rst_pkg::*;

  localparam int N    = 3;
  localparam int HOLD = 8;
  localparam int GAP  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = -3;
  int   n_chk = 0;
  int   n_err = 0;

  typedef struct {
    int           e;
    logic [N-1:0] rst_out;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  secuenciador_rst_if #(.N(N)) bus ();

  secuenciador_rst #(.N(N), .HOLD(HOLD), .GAP(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_window(input int r, input int a, input int b);
    for (int e = a; e <= b; e++) begin
      exp_t x;
      x.e = e;
      for (int i = 0; i < N; i++) x.rst_out[i] = (e < r + HOLD + GAP * i);
      x.busy = |x.rst_out;
      x.done = (e == r + HOLD + GAP * (N - 1));
      sb.push_back(x);
    end
  endtask

  // Returns at the falling edge before edge e, so inputs set now are
  // sampled at edge e.
  task automatic at_edge(input int e);
    if (cyc > e - 1) begin
      $display("FAIL sched: cyc %0d already past edge %0d", cyc, e);
      $fatal(1, "schedule error");
    end
    while (cyc != e - 1) @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].e == cyc) begin
      cur = sb.pop_front();
      chk($sformatf("rst_out@%0d", cur.e), 32'(bus.rst_out), 32'(cur.rst_out));
      chk($sformatf("busy@%0d", cur.e), 32'(bus.busy), 32'(cur.busy));
      chk($sformatf("done@%0d", cur.e), 32'(bus.done), 32'(cur.done));
    end
  end

  initial begin
    bus.ext_req = 1'b0;
    bus.sw_req  = 1'b0;

    // rst held through edge 0: reset state, then free-running sequence.
    push_window(0, -2, 39);
    at_edge(1);
    rst = 1'b0;

    // One-cycle sw_req from IDLE.
    push_window(40, 40, 69);
    at_edge(40); bus.sw_req = 1'b1;
    at_edge(41); bus.sw_req = 1'b0;

    // rst pulse, then sw_req 14 edges later while domains 0/1 are released.
    push_window(70, 70, 83);
    push_window(84, 84, 110);
    at_edge(70); rst = 1'b1;
    at_edge(71); rst = 1'b0;
    at_edge(84); bus.sw_req = 1'b1;
    at_edge(85); bus.sw_req = 1'b0;

    // One-cycle ext_req from IDLE.
`ifdef SECUENCIADOR_RST_FILTRO_EN
    push_window(84, 111, 163);
`else
    push_window(84, 111, 121);
    push_window(122, 122, 161);
`endif
    at_edge(120); bus.ext_req = 1'b1;
    at_edge(121); bus.ext_req = 1'b0;

    // Five-cycle ext_req: last request seen at edge 166 either way.
`ifdef SECUENCIADOR_RST_FILTRO_EN
    push_window(166, 164, 199);
`else
    push_window(166, 162, 199);
`endif
    at_edge(160); bus.ext_req = 1'b1;
    at_edge(165); bus.ext_req = 1'b0;

    // rst pulse 13 edges into a sw_req sequence: no done, restart.
    push_window(200, 200, 212);
    push_window(213, 213, 249);
    at_edge(200); bus.sw_req = 1'b1;
    at_edge(201); bus.sw_req = 1'b0;
    at_edge(213); rst = 1'b1;
    at_edge(214); rst = 1'b0;

    // sw_req held 21 cycles: no release until it drops.
    push_window(270, 250, 300);
    at_edge(250); bus.sw_req = 1'b1;
    at_edge(271); bus.sw_req = 1'b0;

    at_edge(305);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
